load_store_unit: RTL and testbench

Parametrised memory-access unit between the MEM and WB stages. It issues loads and stores to the data RAM over a valid/ready handshake. It tracks up to DEPTH outstanding accesses in order, aligns and extends returned load data, and generates byte-lane write enables and shifted store data. It also detects misaligned addresses. Each access retires as a one-cycle response carrying the destination register, the PC and an address-error flag.

---
 rtl/load_store_unit_if.sv | 47 ++++
 rtl/load_store_unit.sv | 146 ++++++++++++++
 tb/tb_load_store_unit.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request, RAM and response signals of the load/store unit, grouped as one bundle.
// The slave modport is the unit itself; the master modport is the pipeline/RAM side.
interface load_store_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int LANES = DATA_WIDTH / 8;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_sign_ext;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [4:0]            req_reg_addr;
  logic [ADDR_WIDTH-1:0] req_pc;

  logic                  ram_en;
  logic                  ram_ready;
  logic [LANES-1:0]      ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_rvalid;
  logic [DATA_WIDTH-1:0] ram_rdata;

  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_write;
  logic [4:0]            rsp_reg_addr;
  logic [ADDR_WIDTH-1:0] rsp_pc;
  logic                  rsp_addr_error;

  modport slave (
    input  req_valid, req_write, req_size, req_sign_ext, req_addr, req_wdata,
           req_reg_addr, req_pc, ram_ready, ram_rvalid, ram_rdata,
    output req_ready, ram_en, ram_we, ram_addr, ram_wdata,
           rsp_valid, rsp_data, rsp_write, rsp_reg_addr, rsp_pc, rsp_addr_error
  );

  modport master (
    output req_valid, req_write, req_size, req_sign_ext, req_addr, req_wdata,
           req_reg_addr, req_pc, ram_ready, ram_rvalid, ram_rdata,
    input  req_ready, ram_en, ram_we, ram_addr, ram_wdata,
           rsp_valid, rsp_data, rsp_write, rsp_reg_addr, rsp_pc, rsp_addr_error
  );
endinterface

// File: rtl/load_store_unit.sv
// MEM/WB load-store unit: issues RAM accesses, tracks them in order in a small FIFO,
// aligns/extends load data and retires each access as a one-cycle response.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input logic              clk,
  input logic              rst,
  load_store_unit_if.slave bus
);
  localparam int LANES = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(LANES);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [OFF-1:0]        lane;
  logic [2:0]            lane_ext;
  logic                  misaligned;
  logic [7:0]            base_mask;
  logic                  full, empty, push, pop, mis_accept;
  logic [CNT_W-1:0]      count;
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic                  err_pending;

  logic                  fifo_write [DEPTH];
  logic [1:0]            fifo_size  [DEPTH];
  logic                  fifo_sign  [DEPTH];
  logic [OFF-1:0]        fifo_lane  [DEPTH];
  logic [4:0]            fifo_reg   [DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc    [DEPTH];

  logic [DATA_WIDTH-1:0] shifted, keep_mask, load_data;
  logic                  msb;

  logic                  rsp_valid_q, rsp_write_q, rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [4:0]            rsp_reg_q;
  logic [ADDR_WIDTH-1:0] rsp_pc_q;

  assign lane     = bus.req_addr[OFF-1:0];
  assign lane_ext = 3'(lane);

  // Doublewords are never legal on a 32-bit RAM, regardless of address.
  always_comb begin
    misaligned = 1'b0;
    case (bus.req_size)
      2'd1:    misaligned = lane_ext[0];
      2'd2:    misaligned = |lane_ext[1:0];
      2'd3:    misaligned = (|lane_ext) || (LANES < 8);
      default: misaligned = 1'b0;
    endcase
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Misaligned requests bypass the RAM, so they wait for an idle pipe to keep order.
  assign bus.ram_en    = bus.req_valid && !misaligned && !full;
  assign bus.req_ready = misaligned ? (empty && !err_pending) : (bus.ram_en && bus.ram_ready);
  assign push          = bus.ram_en && bus.ram_ready;
  assign mis_accept    = bus.req_valid && misaligned && empty && !err_pending;
  assign pop           = bus.ram_rvalid && !empty;

  always_comb begin
    base_mask = 8'h00;
    case (bus.req_size)
      2'd0:    base_mask = 8'h01;
      2'd1:    base_mask = 8'h03;
      2'd2:    base_mask = 8'h0F;
      default: base_mask = 8'hFF;
    endcase
  end

  assign bus.ram_we    = bus.req_write ? (LANES'(base_mask) << lane) : '0;
  assign bus.ram_wdata = bus.req_wdata << {lane, 3'b000};
  assign bus.ram_addr  = bus.req_addr & ~ADDR_WIDTH'(LANES - 1);

  assign shifted = bus.ram_rdata >> {fifo_lane[rd_ptr], 3'b000};

  // A keep-mask covering the whole word leaves nothing to extend, giving pass-through.
  always_comb begin
    keep_mask = '1;
    msb       = shifted[DATA_WIDTH-1];
    case (fifo_size[rd_ptr])
      2'd0: begin keep_mask = DATA_WIDTH'(8'hFF);         msb = shifted[7];  end
      2'd1: begin keep_mask = DATA_WIDTH'(16'hFFFF);      msb = shifted[15]; end
      2'd2: begin keep_mask = DATA_WIDTH'(32'hFFFF_FFFF); msb = shifted[31]; end
      default: begin keep_mask = '1; msb = shifted[DATA_WIDTH-1]; end
    endcase
    load_data = (shifted & keep_mask) | ((fifo_sign[rd_ptr] && msb) ? ~keep_mask : '0);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_write[wr_ptr] <= bus.req_write;
      fifo_size[wr_ptr]  <= bus.req_size;
      fifo_sign[wr_ptr]  <= bus.req_sign_ext;
      fifo_lane[wr_ptr]  <= lane;
      fifo_reg[wr_ptr]   <= bus.req_reg_addr;
      fifo_pc[wr_ptr]    <= bus.req_pc;
    end
  end

  // Pop and misaligned acceptance are exclusive: the latter needs an empty FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      err_pending <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      rsp_reg_q   <= '0;
      rsp_pc_q    <= '0;
    end else begin
      err_pending <= mis_accept;
      rsp_valid_q <= pop || mis_accept;
      count       <= count + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr      <= rd_ptr + PTR_W'(1);
        rsp_data_q  <= fifo_write[rd_ptr] ? '0 : load_data;
        rsp_write_q <= fifo_write[rd_ptr];
        rsp_reg_q   <= fifo_reg[rd_ptr];
        rsp_pc_q    <= fifo_pc[rd_ptr];
        rsp_err_q   <= 1'b0;
      end else if (mis_accept) begin
        rsp_data_q  <= '0;
        rsp_write_q <= bus.req_write;
        rsp_reg_q   <= bus.req_reg_addr;
        rsp_pc_q    <= bus.req_pc;
        rsp_err_q   <= 1'b1;
      end
    end
  end

  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_data       = rsp_data_q;
  assign bus.rsp_write      = rsp_write_q;
  assign bus.rsp_reg_addr   = rsp_reg_q;
  assign bus.rsp_pc         = rsp_pc_q;
  assign bus.rsp_addr_error = rsp_err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: 32- and 64-bit instances, a latency-programmable RAM model
// and an in-order scoreboard of expected retirements.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;

  load_store_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus32 ();
  load_store_unit_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) bus64 ();

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4)) dut32 (
    .clk(clk), .rst(rst), .bus(bus32)
  );
  load_store_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .DEPTH(4)) dut64 (
    .clk(clk), .rst(rst), .bus(bus64)
  );

  typedef struct {
    logic [63:0] data;
    logic        write;
    logic [4:0]  reg_addr;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  exp_t sb32[$];
  exp_t sb64[$];
  exp_t e32, e64;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] d, input logic w, input logic [4:0] r,
                              input logic [31:0] p, input logic er);
    exp_t e;
    e.data = d; e.write = w; e.reg_addr = r; e.pc = p; e.err = er;
    return e;
  endfunction

  // RAM model: each accepted request completes lat cycles later, in order.
  int lat32 = 2, lat64 = 2;
  int pend32[$], pend64[$];
  int rvalid_cnt32 = 0;
  logic [31:0] rdata32 = '0;
  logic [63:0] rdata64 = '0;
  assign bus32.ram_rdata = rdata32;
  assign bus64.ram_rdata = rdata64;

  always @(negedge clk) begin
    if (!rst && bus32.ram_en && bus32.ram_ready) pend32.push_back(cyc + lat32);
    if (!rst && bus64.ram_en && bus64.ram_ready) pend64.push_back(cyc + lat64);
  end

  always @(posedge clk) begin
    #1;
    bus32.ram_rvalid = 1'b0;
    bus64.ram_rvalid = 1'b0;
    if (pend32.size() > 0 && pend32[0] <= cyc) begin
      void'(pend32.pop_front());
      bus32.ram_rvalid = 1'b1;
      rvalid_cnt32++;
    end
    if (pend64.size() > 0 && pend64[0] <= cyc) begin
      void'(pend64.pop_front());
      bus64.ram_rvalid = 1'b1;
    end
  end

  // Response monitor: pops the scoreboard on every retirement.
  logic prev_rv32 = 1'b0, prev_rv64 = 1'b0;
  int rsp_cnt32 = 0;
  always @(negedge clk) begin
    if (bus32.rsp_valid) begin
      rsp_cnt32++;
      check("rsp32_expected", 64'(sb32.size() > 0), 64'd1);
      if (sb32.size() > 0) begin
        e32 = sb32.pop_front();
        check("rsp32_data",  64'(bus32.rsp_data),       e32.data);
        check("rsp32_write", 64'(bus32.rsp_write),      64'(e32.write));
        check("rsp32_reg",   64'(bus32.rsp_reg_addr),   64'(e32.reg_addr));
        check("rsp32_pc",    64'(bus32.rsp_pc),         64'(e32.pc));
        check("rsp32_err",   64'(bus32.rsp_addr_error), 64'(e32.err));
        if (!e32.err) check("rsp32_latency", 64'(prev_rv32), 64'd1);
      end
    end
    if (bus64.rsp_valid) begin
      check("rsp64_expected", 64'(sb64.size() > 0), 64'd1);
      if (sb64.size() > 0) begin
        e64 = sb64.pop_front();
        check("rsp64_data", bus64.rsp_data,            e64.data);
        check("rsp64_reg",  64'(bus64.rsp_reg_addr),   64'(e64.reg_addr));
        check("rsp64_pc",   64'(bus64.rsp_pc),         64'(e64.pc));
        check("rsp64_err",  64'(bus64.rsp_addr_error), 64'(e64.err));
        if (!e64.err) check("rsp64_latency", 64'(prev_rv64), 64'd1);
      end
    end
    prev_rv32 = bus32.ram_rvalid;
    prev_rv64 = bus64.ram_rvalid;
  end

  task automatic drive32(input logic w, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] r, input logic [31:0] p);
    bus32.req_write = w; bus32.req_size = sz; bus32.req_sign_ext = sx; bus32.req_addr = a;
    bus32.req_wdata = wd; bus32.req_reg_addr = r; bus32.req_pc = p; bus32.req_valid = 1'b1;
  endtask

  task automatic drive64(input logic [1:0] sz, input logic sx, input logic [31:0] a,
                         input logic [4:0] r, input logic [31:0] p);
    bus64.req_write = 1'b0; bus64.req_size = sz; bus64.req_sign_ext = sx; bus64.req_addr = a;
    bus64.req_wdata = '0; bus64.req_reg_addr = r; bus64.req_pc = p; bus64.req_valid = 1'b1;
  endtask

  task automatic wait_accept32(output int acc);
    int n = 0;
    @(negedge clk);
    while (!bus32.req_ready && n < 60) begin n++; @(negedge clk); end
    check("accept32", 64'(bus32.req_ready), 64'd1);
    acc = cyc;
    @(posedge clk); #1;
    bus32.req_valid = 1'b0;
  endtask

  task automatic wait_accept64();
    int n = 0;
    @(negedge clk);
    while (!bus64.req_ready && n < 60) begin n++; @(negedge clk); end
    check("accept64", 64'(bus64.req_ready), 64'd1);
    @(posedge clk); #1;
    bus64.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb32.size() > 0 || sb64.size() > 0) && n < 100) begin n++; @(negedge clk); end
    check("drain", 64'(sb32.size() + sb64.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  int acc;
  int acc_b2b[5];
  int rv_base, rsp_base;

  initial begin
    rst = 1'b1;
    bus32.req_valid = 1'b0; bus64.req_valid = 1'b0;
    drive32(1'b0, 2'd0, 1'b0, '0, '0, '0, '0); bus32.req_valid = 1'b0;
    drive64(2'd0, 1'b0, '0, '0, '0); bus64.req_valid = 1'b0;
    bus32.ram_ready = 1'b1; bus64.ram_ready = 1'b1;
    bus32.ram_rvalid = 1'b0; bus64.ram_rvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rsp_valid", 64'(bus32.rsp_valid), 64'd0);
    check("reset_rsp_data",  64'(bus32.rsp_data), 64'd0);
    check("reset_rsp_write", 64'(bus32.rsp_write), 64'd0);
    check("reset_rsp_reg",   64'(bus32.rsp_reg_addr), 64'd0);
    check("reset_rsp_pc",    64'(bus32.rsp_pc), 64'd0);
    check("reset_rsp_err",   64'(bus32.rsp_addr_error), 64'd0);
    check("reset_ram_en",    64'(bus32.ram_en), 64'd0);
    check("reset64_rsp",     64'(bus64.rsp_valid), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Byte loads from the top lane, signed then unsigned.
    rdata32 = 32'h80FF_1234;
    sb32.push_back(mk(64'hFFFF_FF80, 1'b0, 5'd3, 32'h100, 1'b0));
    drive32(1'b0, 2'd0, 1'b1, 32'h1003, '0, 5'd3, 32'h100);
    wait_accept32(acc);
    drain();
    sb32.push_back(mk(64'h0000_0080, 1'b0, 5'd4, 32'h104, 1'b0));
    drive32(1'b0, 2'd0, 1'b0, 32'h1003, '0, 5'd4, 32'h104);
    wait_accept32(acc);
    drain();

    // Halfword store to the upper half.
    sb32.push_back(mk(64'd0, 1'b1, 5'd5, 32'h108, 1'b0));
    drive32(1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000_ABCD, 5'd5, 32'h108);
    #1;
    check("store_we",    64'(bus32.ram_we), 64'hC);
    check("store_wdata", 64'(bus32.ram_wdata), 64'hABCD_0000);
    check("store_addr",  64'(bus32.ram_addr), 64'h2000);
    check("store_en",    64'(bus32.ram_en), 64'd1);
    wait_accept32(acc);
    drain();

    // Misaligned word load behind two outstanding loads.
    lat32 = 8;
    sb32.push_back(mk(64'h80FF_1234, 1'b0, 5'd6, 32'h10C, 1'b0));
    drive32(1'b0, 2'd2, 1'b0, 32'h1000, '0, 5'd6, 32'h10C);
    wait_accept32(acc);
    sb32.push_back(mk(64'h0000_80FF, 1'b0, 5'd7, 32'h110, 1'b0));
    drive32(1'b0, 2'd1, 1'b0, 32'h1002, '0, 5'd7, 32'h110);
    wait_accept32(acc);
    sb32.push_back(mk(64'd0, 1'b0, 5'd8, 32'h114, 1'b1));
    drive32(1'b0, 2'd2, 1'b0, 32'h3001, '0, 5'd8, 32'h114);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mis_blocked_ready", 64'(bus32.req_ready), 64'd0);
      check("mis_blocked_en",    64'(bus32.ram_en), 64'd0);
    end
    wait_accept32(acc);
    @(negedge clk);
    check("mis_rsp_valid", 64'(bus32.rsp_valid), 64'd1);
    check("mis_rsp_err",   64'(bus32.rsp_addr_error), 64'd1);
    drain();

    // Five back-to-back loads against a depth-4 tracker.
    lat32 = 6;
    for (int i = 0; i < 5; i++) begin
      sb32.push_back(mk(64'h80FF_1234, 1'b0, 5'(10 + i), 32'h200 + 32'(4 * i), 1'b0));
      drive32(1'b0, 2'd2, 1'b0, 32'h4000 + 32'(4 * i), '0, 5'(10 + i), 32'h200 + 32'(4 * i));
      wait_accept32(acc_b2b[i]);
    end
    check("b2b_fourth_cycle", 64'(acc_b2b[3] - acc_b2b[0]), 64'd3);
    check("b2b_fifth_cycle",  64'(acc_b2b[4] - acc_b2b[0]), 64'd7);
    drain();

    // 64-bit data path.
    rdata64 = 64'h89AB_CDEF_0123_4567;
    sb64.push_back(mk(64'h89AB_CDEF_0123_4567, 1'b0, 5'd1, 32'h300, 1'b0));
    drive64(2'd3, 1'b0, 32'h08, 5'd1, 32'h300);
    wait_accept64();
    drain();
    sb64.push_back(mk(64'hFFFF_FFFF_89AB_CDEF, 1'b0, 5'd2, 32'h304, 1'b0));
    drive64(2'd2, 1'b1, 32'h0C, 5'd2, 32'h304);
    wait_accept64();
    drain();
    sb64.push_back(mk(64'd0, 1'b0, 5'd3, 32'h308, 1'b1));
    drive64(2'd3, 1'b0, 32'h04, 5'd3, 32'h308);
    #1;
    check("dword_mis_en", 64'(bus64.ram_en), 64'd0);
    wait_accept64();
    drain();

    // Reset with three loads in flight; their late completions must be ignored.
    lat32 = 10;
    for (int i = 0; i < 3; i++) begin
      drive32(1'b0, 2'd2, 1'b0, 32'h5000 + 32'(4 * i), '0, 5'(20 + i), 32'h400 + 32'(4 * i));
      wait_accept32(acc);
    end
    rv_base = rvalid_cnt32;
    rst = 1'b1;
    #1;
    check("midrst_rsp_valid", 64'(bus32.rsp_valid), 64'd0);
    check("midrst_rsp_pc",    64'(bus32.rsp_pc), 64'd0);
    check("midrst_rsp_reg",   64'(bus32.rsp_reg_addr), 64'd0);
    check("midrst_rsp_data",  64'(bus32.rsp_data), 64'd0);
    check("midrst_ram_en",    64'(bus32.ram_en), 64'd0);
    #1;
    rst = 1'b0;
    rsp_base = rsp_cnt32;
    repeat (15) @(negedge clk);
    check("late_rvalids",  64'(rvalid_cnt32 - rv_base), 64'd3);
    check("late_rsp_none", 64'(rsp_cnt32 - rsp_base), 64'd0);
    @(posedge clk); #1;

    // Tracker still works after the ignored completions.
    lat32 = 1;
    sb32.push_back(mk(64'h0000_1234, 1'b0, 5'd30, 32'h500, 1'b0));
    drive32(1'b0, 2'd1, 1'b0, 32'h6000, '0, 5'd30, 32'h500);
    wait_accept32(acc);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
